page_port_buffer: RTL and testbench
===================================

Name: page_port_buffer

Overview:
- Parametrised, multi-channel elastic buffer between a page's leaf_interface user-side ports and its user_kernel stream ports.
- Each channel is an independent FIFO with vld/ack handshakes on both sides, a synchronous flush and occupancy/traffic counters.
- One instance sits on the input path (interface2user) and a second on the output path (user2interface).
- Lets page wrappers absorb kernel back-pressure and support any NUM_CH instead of a fixed 1-in/1-out pairing.

Parameters:
- NUM_CH, 1, number of independent channels (1..16).
- PAYLOAD_BITS, 32, data width per channel.
- DEPTH_BITS, 3, log2 FIFO depth per channel; depth = 2^DEPTH_BITS (1..8).
- CNT_BITS, 16, width of per-channel transfer counters.

Ports:
- clk  input  1  sole clock, all logic rising-edge.
- reset  input  1  asynchronous active-low reset; 0 clears all state immediately.
- in_data  input  NUM_CH*PAYLOAD_BITS  upstream data; channel c occupies bits [c*PAYLOAD_BITS +: PAYLOAD_BITS].
- in_vld  input  NUM_CH  upstream valid per channel.
- in_ack  output  NUM_CH  buffer accepts word on channel c this cycle.
- out_data  output  NUM_CH*PAYLOAD_BITS  head word per channel, same packing.
- out_vld  output  NUM_CH  head word valid per channel.
- out_ack  input  NUM_CH  downstream takes head word this cycle.
- flush  input  NUM_CH  synchronous per-channel discard of all contents.
- occupancy  output  NUM_CH*(DEPTH_BITS+1)  words held per channel.
- push_cnt  output  NUM_CH*CNT_BITS  accepted words per channel, wraps modulo 2^CNT_BITS.
- pop_cnt  output  NUM_CH*CNT_BITS  delivered words per channel, wraps modulo 2^CNT_BITS.

Behaviour:
- Reset (reset=0, asynchronous):
  - Pointers, occupancy and counters are 0.
  - out_vld=0 and in_ack=0 while reset is low.
  - out_data is 0 after reset.
  - From the first clk edge after reset releases, in_ack follows the rules below.
- Push handshake:
  - Transfer on channel c when in_vld[c] & in_ack[c] at a rising edge.
  - in_ack[c] = !full[c] & !flush[c] & reset_released (combinational from registered state plus flush).
- Pop handshake:
  - Transfer when out_vld[c] & out_ack[c].
  - out_vld[c] = (occupancy[c] != 0), registered state only.
  - out_data[c] is the head entry, stable while out_vld=1 and out_ack=0.
- Latency:
  - A word pushed into an empty channel appears on out_vld/out_data one cycle later.
  - There is no combinational bypass from in to out.
- Full:
  - in_ack=0 even if a pop occurs in the same cycle; no push-through when full.
  - Words are never dropped or overwritten.
- Empty: out_vld=0; out_ack is ignored and pop_cnt does not move.
- Simultaneous push and pop (not full, not empty): occupancy unchanged; both counters increment.
- Wrap-around:
  - Read/write pointers are DEPTH_BITS wide and wrap naturally.
  - Occupancy is a separate DEPTH_BITS+1 counter ranging 0..2^DEPTH_BITS.
- Flush[c]=1 at an edge:
  - Pointers and occupancy of channel c go to 0.
  - out_vld[c]=0 the next cycle.
  - Any concurrent pop on c is not counted; push is blocked because in_ack=0.
  - Counters are NOT cleared by flush; only reset clears them.
- Channel independence: activity or flush on one channel never affects another.
- Counters wrap silently: 2^CNT_BITS-1 + 1 = 0.
- Reset mid-operation: contents are discarded and all outputs take their reset values asynchronously.

Decomposition:
- Shared package page_pkg:
  - constants for default PAYLOAD_BITS=32, DEPTH_BITS, CNT_BITS;
  - a function computing the packed-slice base for channel c.
- One sub-module, page_port_fifo:
  - a single-channel FIFO with counters;
  - instantiated NUM_CH times in a generate loop.
- Top level does packing/unpacking only.

Test Plan:
- Reset then idle, NUM_CH=2, DEPTH_BITS=2:
  - stimulus: drive reset=0 then 1.
  - response: out_vld=00, occupancy all 0; in_ack=11 from the first edge after release.
- Fill to full, channel 0:
  - stimulus: push 0xA0..0xA3 with out_ack=0.
  - response: occupancy=4 and in_ack[0]=0; a fifth word 0xA4 held with in_ack=0 is not accepted; push_cnt=4.
- Drain in order:
  - stimulus: out_ack=1 for four cycles.
  - response: out_data 0xA0,0xA1,0xA2,0xA3; out_vld drops after the 4th; pop_cnt=4; in_ack[0]=1 again.
- Simultaneous push/pop at occupancy 2:
  - response: occupancy stays 2 for 10 cycles.
  - response: order is preserved across pointer wrap, checked against a scoreboard.
- Flush channel 1 holding 3 words while channel 0 streams:
  - response: ch1 occupancy=0, out_vld[1]=0 next cycle, ch1 counters unchanged.
  - response: ch0 stream uninterrupted.
- Counter wrap and async reset:
  - stimulus: CNT_BITS=4, push 17 words.
  - response: push_cnt=1.
  - stimulus: assert reset between clock edges.
  - response: all outputs take reset values before the next edge.

Source files
------------

// File: rtl/page_pkg.sv
// Shared constants and slice helper for the page port buffer.
// Latency: none (package only).
// Backpressure: none (package only).
package page_pkg;

   localparam int PAGE_PAYLOAD_BITS = 32;
   localparam int PAGE_DEPTH_BITS   = 3;
   localparam int PAGE_CNT_BITS     = 16;

   // Low bit of channel ch inside a bus that packs channels of `width` bits each.
   function automatic int ch_base(input int ch, input int width);
      return ch * width;
   endfunction

endpackage

// File: rtl/page_port_fifo.sv
// Single-channel elastic FIFO with synchronous flush and push/pop traffic counters.
// Latency: a word written into an empty FIFO is visible on out_vld/out_data one cycle later.
// Backpressure: in_ack drops when full or flushing, even if a pop happens in the same cycle.
module page_port_fifo
   import page_pkg::*;
#(
   parameter int PAYLOAD_BITS = PAGE_PAYLOAD_BITS,
   parameter int DEPTH_BITS   = PAGE_DEPTH_BITS,
   parameter int CNT_BITS     = PAGE_CNT_BITS
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [PAYLOAD_BITS-1:0] in_data,
   input  logic                    in_vld,
   output logic                    in_ack,
   output logic [PAYLOAD_BITS-1:0] out_data,
   output logic                    out_vld,
   input  logic                    out_ack,
   input  logic                    flush,
   output logic [DEPTH_BITS:0]     occupancy,
   output logic [CNT_BITS-1:0]     push_cnt,
   output logic [CNT_BITS-1:0]     pop_cnt
);

   localparam int DEPTH = 1 << DEPTH_BITS;

   logic [PAYLOAD_BITS-1:0] mem [DEPTH];
   logic [DEPTH_BITS-1:0]   wr_ptr;
   logic [DEPTH_BITS-1:0]   rd_ptr;
   logic                    released;
   logic                    full;
   logic                    push;
   logic                    pop;

   // Full is judged on registered occupancy only, so a same-cycle pop never opens a slot.
   assign full     = (occupancy == (DEPTH_BITS + 1)'(DEPTH));
   assign in_ack   = !full && !flush && released;
   assign out_vld  = (occupancy != '0);
   assign push     = in_vld && in_ack;
   // A pop during flush is swallowed by the flush and not counted.
   assign pop      = out_vld && out_ack && !flush;
   // Gate the head word so out_data reads 0 whenever nothing is held, including right after reset.
   assign out_data = out_vld ? mem[rd_ptr] : '0;

   // Storage array: written on accepted push, contents are don't-care until occupancy covers them.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= in_data;
      end
   end

   // Pointers, occupancy, counters and the post-reset release flag.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         occupancy <= '0;
         push_cnt  <= '0;
         pop_cnt   <= '0;
         released  <= 1'b0;
      end else begin
         released <= 1'b1;
         if (flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
         end else begin
            if (push) begin
               wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
               rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
               2'b10:   occupancy <= occupancy + 1'b1;
               2'b01:   occupancy <= occupancy - 1'b1;
               default: occupancy <= occupancy;
            endcase
         end
         // Counters survive flush and wrap silently.
         if (push) begin
            push_cnt <= push_cnt + 1'b1;
         end
         if (pop) begin
            pop_cnt <= pop_cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/page_port_buffer.sv
// Multi-channel elastic buffer between leaf_interface user ports and user_kernel streams.
// Latency: one cycle from accepted push to out_vld per channel, no in-to-out bypass.
// Backpressure: per-channel in_ack low when that channel is full or flushing; channels are independent.
module page_port_buffer
   import page_pkg::*;
#(
   parameter int NUM_CH       = 1,
   parameter int PAYLOAD_BITS = PAGE_PAYLOAD_BITS,
   parameter int DEPTH_BITS   = PAGE_DEPTH_BITS,
   parameter int CNT_BITS     = PAGE_CNT_BITS
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic [NUM_CH*PAYLOAD_BITS-1:0]   in_data,
   input  logic [NUM_CH-1:0]                in_vld,
   output logic [NUM_CH-1:0]                in_ack,
   output logic [NUM_CH*PAYLOAD_BITS-1:0]   out_data,
   output logic [NUM_CH-1:0]                out_vld,
   input  logic [NUM_CH-1:0]                out_ack,
   input  logic [NUM_CH-1:0]                flush,
   output logic [NUM_CH*(DEPTH_BITS+1)-1:0] occupancy,
   output logic [NUM_CH*CNT_BITS-1:0]       push_cnt,
   output logic [NUM_CH*CNT_BITS-1:0]       pop_cnt
);

   // One independent FIFO per channel; the top only slices the packed buses.
   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      page_port_fifo #(
         .PAYLOAD_BITS (PAYLOAD_BITS),
         .DEPTH_BITS   (DEPTH_BITS),
         .CNT_BITS     (CNT_BITS)
      ) u_fifo (
         .clk       (clk),
         .reset     (reset),
         .in_data   (in_data[ch_base(c, PAYLOAD_BITS) +: PAYLOAD_BITS]),
         .in_vld    (in_vld[c]),
         .in_ack    (in_ack[c]),
         .out_data  (out_data[ch_base(c, PAYLOAD_BITS) +: PAYLOAD_BITS]),
         .out_vld   (out_vld[c]),
         .out_ack   (out_ack[c]),
         .flush     (flush[c]),
         .occupancy (occupancy[ch_base(c, DEPTH_BITS + 1) +: DEPTH_BITS + 1]),
         .push_cnt  (push_cnt[ch_base(c, CNT_BITS) +: CNT_BITS]),
         .pop_cnt   (pop_cnt[ch_base(c, CNT_BITS) +: CNT_BITS])
      );
   end

endmodule

// File: tb/tb_page_port_buffer.sv
// Directed bench for page_port_buffer with two channels, depth 4 and 4-bit counters.
// Latency: inputs driven 1ns after a rising edge, outputs sampled on the falling edge.
// Backpressure: expected in_ack/out_vld/data come from a per-channel queue model plus hand values.
module tb_page_port_buffer;

   localparam int NC    = 2;
   localparam int PB    = 32;
   localparam int DB    = 2;
   localparam int CB    = 4;
   localparam int DEPTH = 4;

   logic                   clk = 1'b0;
   logic                   reset;
   logic [NC*PB-1:0]       in_data;
   logic [NC-1:0]          in_vld;
   logic [NC-1:0]          in_ack;
   logic [NC*PB-1:0]       out_data;
   logic [NC-1:0]          out_vld;
   logic [NC-1:0]          out_ack;
   logic [NC-1:0]          flush;
   logic [NC*(DB+1)-1:0]   occupancy;
   logic [NC*CB-1:0]       push_cnt;
   logic [NC*CB-1:0]       pop_cnt;

   int          checks = 0;
   int          errs   = 0;
   int          ncyc   = 0;
   logic [31:0] mq [NC][$];
   int          mpush [NC];
   int          mpop  [NC];
   logic [31:0] dat   [NC];
   bit          released;

   page_port_buffer #(
      .NUM_CH       (NC),
      .PAYLOAD_BITS (PB),
      .DEPTH_BITS   (DB),
      .CNT_BITS     (CB)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .in_data   (in_data),
      .in_vld    (in_vld),
      .in_ack    (in_ack),
      .out_data  (out_data),
      .out_vld   (out_vld),
      .out_ack   (out_ack),
      .flush     (flush),
      .occupancy (occupancy),
      .push_cnt  (push_cnt),
      .pop_cnt   (pop_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] occ_of(input int c);
      return 32'(occupancy[c*(DB+1) +: DB+1]);
   endfunction

   function automatic logic [31:0] pushc_of(input int c);
      return 32'(push_cnt[c*CB +: CB]);
   endfunction

   function automatic logic [31:0] popc_of(input int c);
      return 32'(pop_cnt[c*CB +: CB]);
   endfunction

   function automatic logic [31:0] data_of(input int c);
      return out_data[c*PB +: PB];
   endfunction

   // One clock: drive, sample at negedge against the model, advance the model at posedge.
   task automatic cycle(input logic [1:0] v, input logic [1:0] a, input logic [1:0] f);
      bit acc [NC];
      bit pp  [NC];
      in_vld  = v;
      out_ack = a;
      flush   = f;
      in_data = {dat[1], dat[0]};
      @(negedge clk);
      ncyc++;
      for (int c = 0; c < NC; c++) begin
         acc[c] = released && (mq[c].size() < DEPTH) && !f[c];
         pp[c]  = (mq[c].size() > 0) && a[c] && !f[c];
         check($sformatf("c%0d ch%0d in_ack", ncyc, c), 32'(in_ack[c]), 32'(acc[c]));
         check($sformatf("c%0d ch%0d out_vld", ncyc, c), 32'(out_vld[c]), 32'(mq[c].size() > 0));
         check($sformatf("c%0d ch%0d occ", ncyc, c), occ_of(c), 32'(mq[c].size()));
         if (mq[c].size() > 0)
            check($sformatf("c%0d ch%0d out_data", ncyc, c), data_of(c), mq[c][0]);
         check($sformatf("c%0d ch%0d push_cnt", ncyc, c), pushc_of(c), 32'(mpush[c] % 16));
         check($sformatf("c%0d ch%0d pop_cnt", ncyc, c), popc_of(c), 32'(mpop[c] % 16));
      end
      @(posedge clk);
      for (int c = 0; c < NC; c++) begin
         if (f[c]) begin
            mq[c].delete();
         end else begin
            if (pp[c]) void'(mq[c].pop_front());
            if (v[c] && acc[c]) mq[c].push_back(dat[c]);
         end
         if (v[c] && acc[c]) begin
            mpush[c]++;
            dat[c] = dat[c] + 1;
         end
         if (pp[c]) mpop[c]++;
      end
      released = 1'b1;
      #1;
   endtask

   task automatic model_reset();
      for (int c = 0; c < NC; c++) begin
         mq[c].delete();
         mpush[c] = 0;
         mpop[c]  = 0;
      end
      released = 1'b0;
   endtask

   initial begin
      reset   = 1'b0;
      in_vld  = '0;
      out_ack = '0;
      flush   = '0;
      in_data = '0;
      dat[0]  = 32'hA0;
      dat[1]  = 32'hC0;
      model_reset();

      // Reset state while reset is held low.
      #12;
      check("rst out_vld", 32'(out_vld), 32'h0);
      check("rst in_ack", 32'(in_ack), 32'h0);
      check("rst occupancy", 32'(occupancy), 32'h0);
      check("rst out_data_lo", out_data[31:0], 32'h0);
      check("rst push_cnt", 32'(push_cnt), 32'h0);

      // Release mid-cycle: in_ack stays low until the first edge after release.
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("pre_edge in_ack", 32'(in_ack), 32'h0);
      @(posedge clk);
      #1;
      released = 1'b1;
      check("post_release in_ack", 32'(in_ack), 32'h3);
      check("post_release out_vld", 32'(out_vld), 32'h0);

      // Fill channel 0 with A0..A3.
      repeat (4) cycle(2'b01, 2'b00, 2'b00);
      check("fill occ0", occ_of(0), 32'd4);
      check("fill in_ack0", 32'(in_ack[0]), 32'h0);
      check("fill push_cnt0", pushc_of(0), 32'd4);

      // A4 held while full is not accepted.
      repeat (2) cycle(2'b01, 2'b00, 2'b00);
      check("hold occ0", occ_of(0), 32'd4);
      check("hold push_cnt0", pushc_of(0), 32'd4);
      check("hold head", data_of(0), 32'hA0);

      // Drain: first beat pops while full with A4 still offered (no push-through).
      cycle(2'b01, 2'b01, 2'b00);
      check("full_pop occ0", occ_of(0), 32'd3);
      check("full_pop push_cnt0", pushc_of(0), 32'd4);
      check("full_pop head", data_of(0), 32'hA1);
      repeat (3) cycle(2'b00, 2'b01, 2'b00);
      check("drain out_vld0", 32'(out_vld[0]), 32'h0);
      check("drain pop_cnt0", popc_of(0), 32'd4);
      check("drain in_ack0", 32'(in_ack[0]), 32'h1);

      // out_ack on empty is ignored.
      cycle(2'b00, 2'b01, 2'b00);
      check("empty pop_cnt0", popc_of(0), 32'd4);

      // Simultaneous push/pop at occupancy 2 across pointer wrap.
      repeat (2) cycle(2'b01, 2'b00, 2'b00);
      repeat (10) cycle(2'b01, 2'b01, 2'b00);
      check("stream occ0", occ_of(0), 32'd2);
      repeat (2) cycle(2'b00, 2'b01, 2'b00);
      check("stream end occ0", occ_of(0), 32'd0);
      check("stream push_cnt0 wrap", pushc_of(0), 32'd0);
      check("stream pop_cnt0 wrap", popc_of(0), 32'd0);

      // Flush channel 1 holding three words while channel 0 streams.
      cycle(2'b11, 2'b00, 2'b00);
      repeat (2) cycle(2'b11, 2'b01, 2'b00);
      check("pre_flush occ1", occ_of(1), 32'd3);
      check("pre_flush push_cnt1", pushc_of(1), 32'd3);
      cycle(2'b11, 2'b11, 2'b10);
      check("flush out_vld1", 32'(out_vld[1]), 32'h0);
      check("flush occ1", occ_of(1), 32'd0);
      check("flush push_cnt1", pushc_of(1), 32'd3);
      check("flush pop_cnt1", popc_of(1), 32'd0);
      check("flush ch0 out_vld", 32'(out_vld[0]), 32'h1);
      repeat (3) cycle(2'b01, 2'b01, 2'b00);

      // Asynchronous reset between clock edges.
      #2;
      reset = 1'b0;
      #1;
      check("arst out_vld", 32'(out_vld), 32'h0);
      check("arst in_ack", 32'(in_ack), 32'h0);
      check("arst occupancy", 32'(occupancy), 32'h0);
      check("arst out_data_lo", out_data[31:0], 32'h0);
      check("arst push_cnt", 32'(push_cnt), 32'h0);
      check("arst pop_cnt", 32'(pop_cnt), 32'h0);
      model_reset();
      in_vld  = '0;
      out_ack = '0;
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      released = 1'b1;

      // Counter wrap: 17 words streamed through channel 1.
      dat[1] = 32'hE0;
      repeat (17) cycle(2'b10, 2'b10, 2'b00);
      cycle(2'b00, 2'b10, 2'b00);
      check("wrap push_cnt1", pushc_of(1), 32'd1);
      check("wrap pop_cnt1", popc_of(1), 32'd1);
      check("wrap occ1", occ_of(1), 32'd0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
